// File: rtl/cyl_to_cart.sv
`default_nettype none
// ============================================================================
// Module      : cyl_to_cart
// Description : Cylindrical (r, theta deg, z) to Cartesian (x, y, z) converter,
//               first quadrant, ROM coefficients and serial shift-add multiply.
// Revision    : 1.0 - initial release
// ============================================================================
module cyl_to_cart #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] r_in,
    input  logic [7:0]        theta_in,
    input  logic [DATA_W-1:0] z_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] x_out,
    output logic [DATA_W-1:0] y_out,
    output logic [DATA_W-1:0] z_out,
    output logic              theta_sat
);

    localparam int         c_coef_w    = 9;
    localparam int         c_acc_w     = DATA_W + c_coef_w;
    localparam logic [6:0] c_theta_max = 7'd90;
    localparam logic [3:0] c_last_iter = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DATA_W-1:0]   r_radius;
    logic [DATA_W-1:0]   r_z;
    logic [c_coef_w-1:0] r_coef_x;
    logic [c_coef_w-1:0] r_coef_y;
    logic                r_sat;
    logic [3:0]          r_cnt;
    logic [c_acc_w-1:0]  r_acc_x;
    logic [c_acc_w-1:0]  r_acc_y;

    logic [6:0]          w_theta;
    logic                w_sat;
    logic [c_acc_w-1:0]  w_addend;
    logic [c_acc_w-1:0]  w_acc_x_nxt;
    logic [c_acc_w-1:0]  w_acc_y_nxt;

    // round(256*cos(t deg)); sine is read as cos(90 - t)
    function automatic logic [c_coef_w-1:0] cos_rom(input logic [6:0] t);
        case (t)
            7'd0:  cos_rom = 9'd256; 7'd1:  cos_rom = 9'd256; 7'd2:  cos_rom = 9'd256; 7'd3:  cos_rom = 9'd256; 7'd4:  cos_rom = 9'd255;
            7'd5:  cos_rom = 9'd255; 7'd6:  cos_rom = 9'd255; 7'd7:  cos_rom = 9'd254; 7'd8:  cos_rom = 9'd254; 7'd9:  cos_rom = 9'd253;
            7'd10: cos_rom = 9'd252; 7'd11: cos_rom = 9'd251; 7'd12: cos_rom = 9'd250; 7'd13: cos_rom = 9'd249; 7'd14: cos_rom = 9'd248;
            7'd15: cos_rom = 9'd247; 7'd16: cos_rom = 9'd246; 7'd17: cos_rom = 9'd245; 7'd18: cos_rom = 9'd243; 7'd19: cos_rom = 9'd242;
            7'd20: cos_rom = 9'd241; 7'd21: cos_rom = 9'd239; 7'd22: cos_rom = 9'd237; 7'd23: cos_rom = 9'd236; 7'd24: cos_rom = 9'd234;
            7'd25: cos_rom = 9'd232; 7'd26: cos_rom = 9'd230; 7'd27: cos_rom = 9'd228; 7'd28: cos_rom = 9'd226; 7'd29: cos_rom = 9'd224;
            7'd30: cos_rom = 9'd222; 7'd31: cos_rom = 9'd219; 7'd32: cos_rom = 9'd217; 7'd33: cos_rom = 9'd215; 7'd34: cos_rom = 9'd212;
            7'd35: cos_rom = 9'd210; 7'd36: cos_rom = 9'd207; 7'd37: cos_rom = 9'd204; 7'd38: cos_rom = 9'd202; 7'd39: cos_rom = 9'd199;
            7'd40: cos_rom = 9'd196; 7'd41: cos_rom = 9'd193; 7'd42: cos_rom = 9'd190; 7'd43: cos_rom = 9'd187; 7'd44: cos_rom = 9'd184;
            7'd45: cos_rom = 9'd181; 7'd46: cos_rom = 9'd178; 7'd47: cos_rom = 9'd175; 7'd48: cos_rom = 9'd171; 7'd49: cos_rom = 9'd168;
            7'd50: cos_rom = 9'd165; 7'd51: cos_rom = 9'd161; 7'd52: cos_rom = 9'd158; 7'd53: cos_rom = 9'd154; 7'd54: cos_rom = 9'd150;
            7'd55: cos_rom = 9'd147; 7'd56: cos_rom = 9'd143; 7'd57: cos_rom = 9'd139; 7'd58: cos_rom = 9'd136; 7'd59: cos_rom = 9'd132;
            7'd60: cos_rom = 9'd128; 7'd61: cos_rom = 9'd124; 7'd62: cos_rom = 9'd120; 7'd63: cos_rom = 9'd116; 7'd64: cos_rom = 9'd112;
            7'd65: cos_rom = 9'd108; 7'd66: cos_rom = 9'd104; 7'd67: cos_rom = 9'd100; 7'd68: cos_rom = 9'd96;  7'd69: cos_rom = 9'd92;
            7'd70: cos_rom = 9'd88;  7'd71: cos_rom = 9'd83;  7'd72: cos_rom = 9'd79;  7'd73: cos_rom = 9'd75;  7'd74: cos_rom = 9'd71;
            7'd75: cos_rom = 9'd66;  7'd76: cos_rom = 9'd62;  7'd77: cos_rom = 9'd58;  7'd78: cos_rom = 9'd53;  7'd79: cos_rom = 9'd49;
            7'd80: cos_rom = 9'd44;  7'd81: cos_rom = 9'd40;  7'd82: cos_rom = 9'd36;  7'd83: cos_rom = 9'd31;  7'd84: cos_rom = 9'd27;
            7'd85: cos_rom = 9'd22;  7'd86: cos_rom = 9'd18;  7'd87: cos_rom = 9'd13;  7'd88: cos_rom = 9'd9;   7'd89: cos_rom = 9'd4;
            default: cos_rom = 9'd0;
        endcase
    endfunction

    assign w_sat   = (theta_in > {1'b0, c_theta_max});
    assign w_theta = w_sat ? c_theta_max : theta_in[6:0];

    // Both products share one shift schedule: bit r_cnt of each coefficient
    assign w_addend    = {{c_coef_w{1'b0}}, r_radius} << r_cnt;
    assign w_acc_x_nxt = r_acc_x + (r_coef_x[r_cnt] ? w_addend : '0);
    assign w_acc_y_nxt = r_acc_y + (r_coef_y[r_cnt] ? w_addend : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = MUL;
            end
            MUL:  if (r_cnt == c_last_iter) w_state_nxt = DONE;
            DONE: if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_radius  <= '0;
            r_z       <= '0;
            r_coef_x  <= '0;
            r_coef_y  <= '0;
            r_sat     <= 1'b0;
            r_cnt     <= '0;
            r_acc_x   <= '0;
            r_acc_y   <= '0;
            x_out     <= '0;
            y_out     <= '0;
            z_out     <= '0;
            theta_sat <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_radius <= r_in;
                        r_z      <= z_in;
                        r_coef_x <= cos_rom(w_theta);
                        r_coef_y <= cos_rom(c_theta_max - w_theta);
                        r_sat    <= w_sat;
                        r_cnt    <= '0;
                        r_acc_x  <= '0;
                        r_acc_y  <= '0;
                    end
                end
                MUL: begin
                    r_acc_x <= w_acc_x_nxt;
                    r_acc_y <= w_acc_y_nxt;
                    if (r_cnt == c_last_iter) begin
                        r_cnt     <= '0;
                        x_out     <= w_acc_x_nxt[DATA_W+7:8];
                        y_out     <= w_acc_y_nxt[DATA_W+7:8];
                        z_out     <= r_z;
                        theta_sat <= r_sat;
                        out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cyl_to_cart.sv
`default_nettype none
// ============================================================================
// Module      : tb_cyl_to_cart
// Description : Randomized self-checking bench for cyl_to_cart against a
//               trigonometric reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cyl_to_cart;

    localparam int DATA_W     = 8;
    localparam int c_wait     = 40;
    localparam int c_b2b_n    = 8;
    localparam int c_b2b_cyc  = 200;
    localparam int c_rand_ops = 12;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] r_in;
    logic [7:0]        theta_in;
    logic [DATA_W-1:0] z_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] x_out;
    logic [DATA_W-1:0] y_out;
    logic [DATA_W-1:0] z_out;
    logic              theta_sat;

    int n_checks = 0;
    int n_fail   = 0;

    cyl_to_cart #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .r_in      (r_in),
        .theta_in  (theta_in),
        .z_in      (z_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .z_out     (z_out),
        .theta_sat (theta_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Coefficient straight from the trig definition, rounded to nearest
    function automatic int coef(input int t, input bit is_sin);
        real a;
        real v;
        a = t * 3.14159265358979 / 180.0;
        v = is_sin ? $sin(a) : $cos(a);
        return $rtoi(256.0 * v + 0.5);
    endfunction

    function automatic int model_x(input int r, input int th);
        int t;
        t = (th > 90) ? 90 : th;
        return (r * coef(t, 1'b0)) / 256;
    endfunction

    function automatic int model_y(input int r, input int th);
        int t;
        t = (th > 90) ? 90 : th;
        return (r * coef(t, 1'b1)) / 256;
    endfunction

    task automatic scramble_inputs();
        in_valid = 1'($urandom_range(0, 1));
        r_in     = DATA_W'($urandom);
        theta_in = 8'($urandom);
        z_in     = DATA_W'($urandom);
    endtask

    task automatic do_op(input logic [7:0] r, input logic [7:0] th, input logic [7:0] z, input int hold);
        int n;
        int ex;
        int ey;
        logic es;
        ex = model_x(r, th);
        ey = model_y(r, th);
        es = (th > 8'd90);
        in_valid  = 1'b1;
        r_in      = r;
        theta_in  = th;
        z_in      = z;
        out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < c_wait) begin
            @(posedge clk); #1; n++;
        end
        check("accept_wait", 32'(n < c_wait), 32'd1);
        @(posedge clk); #1;
        n = 0;
        while (!out_valid && n < c_wait) begin
            scramble_inputs();
            @(posedge clk); #1; n++;
        end
        check("latency", n, 9);
        check("x", x_out, ex);
        check("y", y_out, ey);
        check("z", z_out, z);
        check("theta_sat", theta_sat, es);
        for (int i = 0; i < hold; i++) begin
            scramble_inputs();
            @(posedge clk); #1;
            check("backpressure_hold", {out_valid, in_ready, x_out, y_out, z_out, theta_sat},
                  {1'b1, 1'b0, ex[7:0], ey[7:0], z, es});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_valid", out_valid, 1'b0);
        check("release_ready", in_ready, 1'b1);
        check("retain_xy", {x_out, y_out}, {ex[7:0], ey[7:0]});
        out_ready = 1'b0;
    endtask

    logic [7:0] d_r [9] = '{8'd200, 8'd200, 8'd255, 8'd200, 8'd100, 8'd100, 8'd200, 8'd10, 8'd0};
    logic [7:0] d_t [9] = '{8'd0,   8'd90,  8'd0,   8'd45,  8'd30,  8'd60,  8'd200, 8'd0,  8'd37};

    initial begin
        int n;
        int seen;
        int accepted;
        int results;
        int last_cyc;
        int q_x[$];
        int q_y[$];
        int q_z[$];
        int q_s[$];

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        r_in      = '0;
        theta_in  = '0;
        z_in      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_outputs", {x_out, y_out, z_out, theta_sat}, 25'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_in_ready", in_ready, 1'b1);
        check("idle_out_valid", out_valid, 1'b0);

        for (int i = 0; i < 9; i++)
            do_op(d_r[i], d_t[i], (i == 3) ? 8'h5A : 8'($urandom), (i == 3) ? 5 : 1);

        for (int i = 0; i < c_rand_ops; i++)
            do_op(8'($urandom), 8'($urandom_range(0, 120)), 8'($urandom), int'($urandom_range(0, 5)));

        // Reset in the middle of a multiply discards the operation
        in_valid = 1'b1;
        r_in     = 8'd200;
        theta_in = 8'd45;
        z_in     = 8'h33;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mul_in_ready_low", in_ready, 1'b0);
        rst = 1'b1;
        #1;
        check("midop_rst_in_ready", in_ready, 1'b1);
        check("midop_rst_outputs", {out_valid, x_out, y_out, z_out, theta_sat}, 26'd0);
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("midop_rst_no_output", seen, 0);
        check("midop_rst_ready_after", in_ready, 1'b1);

        // Back-to-back with out_ready held high
        accepted  = 0;
        results   = 0;
        last_cyc  = -1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        r_in      = 8'($urandom);
        theta_in  = 8'($urandom_range(0, 120));
        z_in      = 8'($urandom);
        for (int cyc = 0; cyc < c_b2b_cyc && results < c_b2b_n; cyc++) begin
            bit acc_now;
            acc_now = in_valid && in_ready;
            if (acc_now) begin
                q_x.push_back(model_x(r_in, theta_in));
                q_y.push_back(model_y(r_in, theta_in));
                q_z.push_back(int'(z_in));
                q_s.push_back(int'(theta_in > 8'd90));
            end
            if (out_valid && out_ready) begin
                if (q_x.size() == 0) begin
                    check("b2b_spurious", 32'd1, 32'd0);
                end else begin
                    check("b2b_result", {x_out, y_out, z_out, theta_sat},
                          {8'(q_x.pop_front()), 8'(q_y.pop_front()), 8'(q_z.pop_front()), 1'(q_s.pop_front())});
                end
                if (last_cyc >= 0) check("b2b_period", cyc - last_cyc, 11);
                last_cyc = cyc;
                results++;
            end
            @(posedge clk); #1;
            if (acc_now) begin
                accepted++;
                if (accepted == c_b2b_n) begin
                    in_valid = 1'b0;
                end else begin
                    r_in     = 8'($urandom);
                    theta_in = 8'($urandom_range(0, 120));
                    z_in     = 8'($urandom);
                end
            end
        end
        check("b2b_count", results, c_b2b_n);
        check("b2b_accepted", accepted, c_b2b_n);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
